// File: rtl/decode_stage.sv
// decode_stage
//   Registered instruction-decode stage between fetch and execute. Decodes
//   ld, sd, and, or, add, sub and beq into the core's control fields, holds
//   them in a single output slot with a valid/ready handshake, and supports
//   a synchronous flush from downstream.
//
//   Optional feature macro: LOAD_USE_STALL_EN
//     defined   -> load-use hazard stall plus saturating bubble counter
//     undefined -> no stall logic; bubble_count is tied to zero
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   fetch-side handshake, inst is the instruction word
//   flush               kill the slot and refuse input this cycle
//   out_valid/out_ready execute-side handshake
//   reg_write_enable, data_write_enable, reg_write_select, branch
//                       control flags
//   reg_read_addr_1/2, reg_write_addr  register addresses (REG_ADDR_W)
//   data_addr           data-memory address (DATA_ADDR_W)
//   alu_ctrl            00 and, 01 or, 10 add, 11 sub
//   branch_offset       beq offset in halfwords (BR_OFF_W)
//   illegal             word matched no supported instruction
//   bubble_count        saturating count of inserted load-use bubbles
module decode_stage #(
    parameter int REG_ADDR_W  = 5,
    parameter int DATA_ADDR_W = 5,
    parameter int BR_OFF_W    = 5,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            inst,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   reg_write_enable,
    output logic                   data_write_enable,
    output logic                   reg_write_select,
    output logic                   branch,
    output logic [REG_ADDR_W-1:0]  reg_read_addr_1,
    output logic [REG_ADDR_W-1:0]  reg_read_addr_2,
    output logic [REG_ADDR_W-1:0]  reg_write_addr,
    output logic [DATA_ADDR_W-1:0] data_addr,
    output logic [1:0]             alu_ctrl,
    output logic [BR_OFF_W-1:0]    branch_offset,
    output logic                   illegal,
    output logic [CNT_W-1:0]       bubble_count
);

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic                   reg_write_enable;
        logic                   data_write_enable;
        logic                   reg_write_select;
        logic                   branch;
        logic [REG_ADDR_W-1:0]  rs1;
        logic [REG_ADDR_W-1:0]  rs2;
        logic [REG_ADDR_W-1:0]  rd;
        logic [DATA_ADDR_W-1:0] data_addr;
        alu_op_e                alu_ctrl;
        logic [BR_OFF_W-1:0]    branch_offset;
        logic                   illegal;
    } fields_t;

    fields_t dec;
    fields_t slot;

    logic [16:0]            key;
    logic [REG_ADDR_W-1:0]  f_rs1;
    logic [REG_ADDR_W-1:0]  f_rs2;
    logic [REG_ADDR_W-1:0]  f_rd;
    logic [DATA_ADDR_W-1:0] ld_addr;
    logic [DATA_ADDR_W-1:0] sd_addr;
    logic [BR_OFF_W-1:0]    br_off;
    logic                   load;
    logic                   hazard;

    assign key   = {inst[31:25], inst[14:12], inst[6:0]};
    assign f_rs1 = REG_ADDR_W'(inst[19:15]);
    assign f_rs2 = REG_ADDR_W'(inst[24:20]);
    assign f_rd  = REG_ADDR_W'(inst[11:7]);

    // Address arithmetic is done at the output width so the sum wraps
    // modulo 2^DATA_ADDR_W without any wider intermediate.
    assign ld_addr = DATA_ADDR_W'(inst[19:15]) + DATA_ADDR_W'(inst[31:20]);
    assign sd_addr = DATA_ADDR_W'(inst[19:15]) + DATA_ADDR_W'({inst[31:25], inst[11:7]});
    assign br_off  = BR_OFF_W'({inst[31], inst[7], inst[30:25], inst[11:8]});

    // NOTE: every field gets a default before the case so no path can leave
    // a field unassigned and infer a latch.
    always_comb begin
        dec = '0;
        casez (key)
            17'b???????_011_0000011: begin  // ld
                dec.reg_write_enable = 1'b1;
                dec.rd               = f_rd;
                dec.data_addr        = ld_addr;
            end
            17'b???????_011_0100011: begin  // sd: port 1 reads the store data
                dec.rs1               = f_rs2;
                dec.data_write_enable = 1'b1;
                dec.data_addr         = sd_addr;
            end
            17'b0000000_111_0110011,         // and
            17'b0000000_110_0110011,         // or
            17'b0000000_000_0110011,         // add
            17'b0100000_000_0110011: begin   // sub
                dec.rs1              = f_rs1;
                dec.rs2              = f_rs2;
                dec.rd               = f_rd;
                dec.reg_write_enable = 1'b1;
                dec.reg_write_select = 1'b1;
                if (inst[30])
                    dec.alu_ctrl = ALU_SUB;
                else if (inst[14:12] == 3'b111)
                    dec.alu_ctrl = ALU_AND;
                else if (inst[14:12] == 3'b110)
                    dec.alu_ctrl = ALU_OR;
                else
                    dec.alu_ctrl = ALU_ADD;
            end
            17'b???????_000_1100011: begin  // beq
                dec.rs1           = f_rs1;
                dec.rs2           = f_rs2;
                dec.alu_ctrl      = ALU_SUB;
                dec.branch        = 1'b1;
                dec.branch_offset = br_off;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign in_ready = (!out_valid || out_ready) && !flush && !hazard;
    assign load     = in_valid && in_ready;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            slot      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            slot      <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LOAD_USE_STALL_EN
    logic             slot_is_ld;
    logic [CNT_W-1:0] bubble_q;

    // Only ld writes a register through the memory path (select = 0).
    assign slot_is_ld = out_valid && slot.reg_write_enable && !slot.reg_write_select
                        && (slot.rd != '0);
    assign hazard     = in_valid && slot_is_ld
                        && ((dec.rs1 == slot.rd) || (dec.rs2 == slot.rd));

    // A bubble exists only when the ld actually leaves while the consumer is
    // held back; a flush in the same cycle discards it instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_q <= '0;
        else if (hazard && out_ready && !flush && (bubble_q != '1))
            bubble_q <= bubble_q + 1'b1;
    end

    assign bubble_count = bubble_q;
`else
    assign hazard       = 1'b0;
    assign bubble_count = '0;
`endif

    assign reg_write_enable  = slot.reg_write_enable;
    assign data_write_enable = slot.data_write_enable;
    assign reg_write_select  = slot.reg_write_select;
    assign branch            = slot.branch;
    assign reg_read_addr_1   = slot.rs1;
    assign reg_read_addr_2   = slot.rs2;
    assign reg_write_addr    = slot.rd;
    assign data_addr         = slot.data_addr;
    assign alu_ctrl          = slot.alu_ctrl;
    assign branch_offset     = slot.branch_offset;
    assign illegal           = slot.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the single-issue RISC-V core. It sits between fetch and execute and decodes ld, sd, and, or, add, sub and beq into the same control fields the core already uses. Unlike the plain combinational decoder, it adds full immediates, configurable field widths, a valid/ready handshake and flush. It also provides optional load-use bubble insertion and a bubble performance counter.

## Interface
Parameters:
- REG_ADDR_W, 5: register-address field width (≥5; upper bits zero-filled)
- DATA_ADDR_W, 5: data-memory address width
- BR_OFF_W, 5: branch-offset output width (halfword units)
- CNT_W, 16: bubble-counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents inst
- in_ready  out  1  stage accepts inst this cycle
- inst  in  32  instruction word
- flush  in  1  synchronous kill (branch taken downstream)
- out_valid  out  1  decoded fields valid
- out_ready  in  1  execute consumes this cycle
- reg_write_enable, data_write_enable, reg_write_select, branch  out  1 each  control flags
- reg_read_addr_1, reg_read_addr_2, reg_write_addr  out  REG_ADDR_W  register addresses
- data_addr  out  DATA_ADDR_W  memory address
- alu_ctrl  out  2  00 and, 01 or, 10 add, 11 sub
- branch_offset  out  BR_OFF_W  branch target offset
- illegal  out  1  decoded word matched no supported instruction
- bubble_count  out  CNT_W  saturating count of inserted load-use bubbles

## Operation
- Decode key: {inst[31:25], inst[14:12], inst[6:0]}.
- **ld** (funct3 011, opcode 0000011):
  - wen=1, write addr=rd, read addrs=0, select=0.
  - data_addr = (rs1 field + inst[31:20]) mod 2^DATA_ADDR_W.
- **sd** (funct3 011, opcode 0100011):
  - read_addr_1=inst[24:20], dwe=1.
  - data_addr = (rs1 field + {inst[31:25],inst[11:7]}) mod 2^DATA_ADDR_W.
- **and/or/add/sub** (opcode 0110011, funct7 0000000; sub uses 0100000):
  - read_addr_1=rs1, read_addr_2=rs2, write addr=rd, wen=1, select=1.
  - alu_ctrl per the code table above.
- **beq** (funct3 000, opcode 1100011):
  - read_addr_1=rs1, read_addr_2=rs2, alu_ctrl=11, branch=1.
  - branch_offset = {inst[31],inst[7],inst[30:25],inst[11:8]} truncated to its low BR_OFF_W bits.
- **Other encodings**: all fields 0 and illegal=1; the word still occupies a slot (out_valid=1).
- **Slot**: one output register.
  - Load when in_valid && in_ready.
  - Clear out_valid when out_ready && !load.
- in_ready = (!out_valid || out_ready) && !flush && !hazard.
- **flush** has top priority: out_valid←0 next cycle and the input is not accepted.
- **Load-use hazard** (only with the macro enabled):
  - Condition: the slot holds a valid ld with rd≠0, and the incoming valid inst's decoded read_addr_1 or read_addr_2 equals that rd.
  - Effect: in_ready=0 for that cycle. When the ld leaves, the slot becomes empty (a bubble) and bubble_count increments, saturating at all-ones.
- The counter does not increment on hazard cycles where out_ready=0.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 instruction/cycle with no hazards.
- Reset values: out_valid=0, every decoded field=0, illegal=0, bubble_count=0. in_ready=1 after reset release (combinational).
- Reset mid-operation discards the slot immediately (asynchronous).
- Hold rule: while out_valid && !out_ready, all outputs are held stable.
- Simultaneous flush and hazard: flush wins; no bubble is counted.
- Simultaneous flush and out_ready: the slot empties; nothing is accepted.

## Configuration
- LOAD_USE_STALL_EN defined: hazard logic and bubble_count are active as described.
- LOAD_USE_STALL_EN undefined:
  - hazard is constant 0, so in_ready = (!out_valid || out_ready) && !flush.
  - bubble_count is tied to 0.
  - The compiler schedules around load-use.

## Test plan
- Reset with rst_n=0 mid-stream -> out_valid=0, all outputs 0, bubble_count=0 within the same cycle.
- ld x3,4(x1) = 0x0040B183, out_ready=1 -> next cycle: out_valid=1, reg_write_addr=3, data_addr=5, reg_write_enable=1.
- Back-to-back stream, out_ready=1:
  - Words: sub x6,x1,x2 = 0x40208333, then beq x1,x2,+8 = 0x00208463.
  - Expect: alu_ctrl=11 with reg_write_addr=6, then branch=1 with branch_offset=4. No gaps.
- ld 0x0040B183 followed by add x5,x3,x2 = 0x002182B3, macro on:
  - Expect: one cycle with in_ready=0, then an out_valid=0 bubble; add emerges 2 cycles after ld; bubble_count=1.
  - Macro off: add emerges 1 cycle after ld and bubble_count=0.
- out_ready held 0 for 3 cycles -> outputs stable and in_ready=0. On release, the next word is accepted the same cycle.
- flush asserted while holding add, with in_valid=1 -> next cycle out_valid=0 and the input word is not accepted. An undefined word 0xFFFFFFFF afterwards gives illegal=1 with all fields 0.
